cp0_unit: RTL and testbench

Coprocessor-0 exception responder for the five-stage MIPS core. Sits beside the M stage, holds SR/Cause/EPC/PRId, samples exception requests from the pipeline and the six external hardware interrupt lines, and decides whether to take an exception. It produces the exception-taken pulse and saved EPC that the next-PC logic consumes to redirect fetch to the handler at 0x0000_4180 or back to EPC on `eret`.

---
 rtl/cp0_pkg.sv | 26 ++
 rtl/cp0_exc_arbiter.sv | 24 ++
 rtl/cp0_unit.sv | 116 +++++++++++
 tb/tb_cp0_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, handler entry and SR/Cause field positions.
// Pure declarations, no logic.
package cp0_pkg;

  localparam logic [4:0]  CP0_REG_SR    = 5'd12;
  localparam logic [4:0]  CP0_REG_CAUSE = 5'd13;
  localparam logic [4:0]  CP0_REG_EPC   = 5'd14;
  localparam logic [4:0]  CP0_REG_PRID  = 5'd15;

  localparam logic [4:0]  EXC_INT  = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_ADES = 5'd5;
  localparam logic [4:0]  EXC_RI   = 5'd10;
  localparam logic [4:0]  EXC_OV   = 5'd12;

  localparam logic [31:0] CP0_HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] CP0_PRID_DEFAULT = 32'h2020_0700;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LSB    = 10;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_BD_BIT  = 31;

endpackage

// File: rtl/cp0_exc_arbiter.sv
// Decides whether an interrupt or internal exception is taken this cycle and picks its ExcCode.
// Purely combinational, zero latency; no handshake, EXL masks all requests.
module cp0_exc_arbiter
  import cp0_pkg::*;
(
  input  logic [5:0] i_hw_int,
  input  logic [5:0] i_sr_im,
  input  logic       i_sr_ie,
  input  logic       i_sr_exl,
  input  logic       i_exc_valid,
  input  logic [4:0] i_exc_code,
  output logic       o_int_req,
  output logic       o_exc_req,
  output logic       o_exc_taken,
  output logic [4:0] o_exc_code
);

  assign o_int_req   = (|(i_hw_int & i_sr_im)) & i_sr_ie & ~i_sr_exl;
  assign o_exc_req   = i_exc_valid & ~i_sr_exl;
  assign o_exc_taken = o_int_req | o_exc_req;
  // An interrupt outranks the internal exception of the instruction it interrupts.
  assign o_exc_code  = o_int_req ? EXC_INT : i_exc_code;

endmodule

// File: rtl/cp0_unit.sv
// CP0 SR/Cause/EPC/PRId holder and exception responder beside M; exc_taken is same-cycle, state updates next edge.
// No backpressure. Optional CP0_EPC_FWD_EN forwards a same-cycle mtc0 EPC onto epc_out.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL     = CP0_PRID_DEFAULT,
  parameter logic [31:0] HANDLER_ADDR = CP0_HANDLER_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret_m,
  output logic [31:0] cp0_rdata,
  output logic        exc_taken,
  output logic [31:0] epc_out
);

  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_exc_taken;
  logic [4:0]  w_exc_code;
  logic [31:0] w_exc_pc;
  logic        w_unused;

  cp0_exc_arbiter u_arb (
    .i_hw_int    (hw_int),
    .i_sr_im     (r_sr_im),
    .i_sr_ie     (r_sr_ie),
    .i_sr_exl    (r_sr_exl),
    .i_exc_valid (exc_valid),
    .i_exc_code  (exc_code),
    .o_int_req   (w_int_req),
    .o_exc_req   (w_exc_req),
    .o_exc_taken (w_exc_taken),
    .o_exc_code  (w_exc_code)
  );

  // A delay-slot instruction restarts at its branch so the branch is re-executed.
  assign w_exc_pc = bd_m ? (pc_m - 32'd4) : pc_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr_im     <= '0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= '0;
      r_cause_exc <= '0;
      r_epc       <= '0;
    end else begin
      r_cause_ip <= hw_int;
      if (w_exc_taken) begin
        r_sr_exl    <= 1'b1;
        r_cause_exc <= w_exc_code;
        r_cause_bd  <= bd_m;
        r_epc       <= {w_exc_pc[31:2], 2'b00};
      end else if (eret_m) begin
        r_sr_exl <= 1'b0;
      end else if (cp0_we) begin
        if (cp0_addr == CP0_REG_SR) begin
          r_sr_im  <= cp0_wdata[SR_IM_LSB +: 6];
          r_sr_exl <= cp0_wdata[SR_EXL_BIT];
          r_sr_ie  <= cp0_wdata[SR_IE_BIT];
        end else if (cp0_addr == CP0_REG_EPC) begin
          r_epc <= {cp0_wdata[31:2], 2'b00};
        end
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_REG_SR: begin
        cp0_rdata[SR_IM_LSB +: 6] = r_sr_im;
        cp0_rdata[SR_EXL_BIT]     = r_sr_exl;
        cp0_rdata[SR_IE_BIT]      = r_sr_ie;
      end
      CP0_REG_CAUSE: begin
        cp0_rdata[CAUSE_BD_BIT]          = r_cause_bd;
        cp0_rdata[CAUSE_IP_LSB +: 6]     = r_cause_ip;
        cp0_rdata[CAUSE_EXC_LSB +: 5]    = r_cause_exc;
      end
      CP0_REG_EPC:  cp0_rdata = r_epc;
      CP0_REG_PRID: cp0_rdata = PRID_VAL;
      default:      cp0_rdata = '0;
    endcase
  end

  assign exc_taken = w_exc_taken;

`ifdef CP0_EPC_FWD_EN
  assign epc_out = (cp0_we && (cp0_addr == CP0_REG_EPC) && !w_exc_taken)
                   ? {cp0_wdata[31:2], 2'b00} : r_epc;
`else
  assign epc_out = r_epc;
`endif

  assign w_unused = ^{cp0_wdata[1:0], HANDLER_ADDR, w_int_req, w_exc_req};

endmodule

// File: tb/tb_cp0_unit.sv
// Directed table-driven bench for cp0_unit: one row per clock cycle, combinational outputs checked before the edge.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        eret_m;
  logic [31:0] cp0_rdata;
  logic        exc_taken;
  logic [31:0] epc_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk       (clk),
    .reset     (reset),
    .pc_m      (pc_m),
    .bd_m      (bd_m),
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .hw_int    (hw_int),
    .cp0_we    (cp0_we),
    .cp0_addr  (cp0_addr),
    .cp0_wdata (cp0_wdata),
    .eret_m    (eret_m),
    .cp0_rdata (cp0_rdata),
    .exc_taken (exc_taken),
    .epc_out   (epc_out)
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        bd;
    logic        ev;
    logic [4:0]  code;
    logic [5:0]  hw;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic        chk;
    logic        x_taken;
    logic [31:0] x_epc;
    logic [31:0] x_rdata;
  } vec_t;

  localparam int NV = 37;
  vec_t vecs [NV];

`ifdef CP0_EPC_FWD_EN
  localparam logic [31:0] FWD_EPC = 32'h0000_3000;
`else
  localparam logic [31:0] FWD_EPC = 32'h0000_0000;
`endif

  function automatic vec_t mk(logic rst, logic [31:0] pc, logic bd, logic ev, logic [4:0] code,
                              logic [5:0] hw, logic we, logic [4:0] addr, logic [31:0] wdata,
                              logic eret, logic chk, logic x_taken, logic [31:0] x_epc,
                              logic [31:0] x_rdata);
    vec_t v;
    v.rst = rst; v.pc = pc; v.bd = bd; v.ev = ev; v.code = code; v.hw = hw;
    v.we = we; v.addr = addr; v.wdata = wdata; v.eret = eret; v.chk = chk;
    v.x_taken = x_taken; v.x_epc = x_epc; v.x_rdata = x_rdata;
    return v;
  endfunction

  task automatic check32(string name, int row, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  initial begin
    //           rst pc            bd ev code   hw       we addr   wdata          er chk tk epc            rdata
    vecs[0]  = mk(1, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd15, 32'h0,         0, 0, 0, 32'h0,         32'h0);
    vecs[1]  = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd15, 32'h0,         0, 1, 0, 32'h0,         32'h2020_0700);
    vecs[2]  = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd12, 32'h0,         0, 1, 0, 32'h0,         32'h0);
    vecs[3]  = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd13, 32'h0,         0, 1, 0, 32'h0,         32'h0);
    vecs[4]  = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd14, 32'h0,         0, 1, 0, 32'h0,         32'h0);
    vecs[5]  = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    1, 5'd12, 32'h0000_0401, 0, 1, 0, 32'h0,         32'h0);
    vecs[6]  = mk(0, 32'h0000_1000,0, 0, 5'd0,  6'b1,    0, 5'd12, 32'h0,         0, 1, 1, 32'h0,         32'h0000_0401);
    vecs[7]  = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd13, 32'h0,         0, 1, 0, 32'h0000_1000, 32'h0000_0400);
    vecs[8]  = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd12, 32'h0,         0, 1, 0, 32'h0000_1000, 32'h0000_0403);
    vecs[9]  = mk(0, 32'h0000_3010,1, 1, 5'd12, 6'b0,    0, 5'd13, 32'h0,         0, 1, 0, 32'h0000_1000, 32'h0);
    vecs[10] = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd12, 32'h0,         1, 1, 0, 32'h0000_1000, 32'h0000_0403);
    vecs[11] = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd12, 32'h0,         0, 1, 0, 32'h0000_1000, 32'h0000_0401);
    vecs[12] = mk(0, 32'h0000_3010,1, 1, 5'd12, 6'b0,    0, 5'd14, 32'h0,         0, 1, 1, 32'h0000_1000, 32'h0000_1000);
    vecs[13] = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd13, 32'h0,         0, 1, 0, 32'h0000_300C, 32'h8000_0030);
    vecs[14] = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd14, 32'h0,         0, 1, 0, 32'h0000_300C, 32'h0000_300C);
    vecs[15] = mk(0, 32'h0,        0, 0, 5'd0,  6'b1,    0, 5'd12, 32'h0,         0, 1, 0, 32'h0000_300C, 32'h0000_0403);
    vecs[16] = mk(0, 32'h0,        0, 0, 5'd0,  6'b1,    0, 5'd12, 32'h0,         1, 1, 0, 32'h0000_300C, 32'h0000_0403);
    vecs[17] = mk(0, 32'h0000_2000,0, 0, 5'd0,  6'b1,    1, 5'd14, 32'h1234_5678, 0, 1, 1, 32'h0000_300C, 32'h0000_300C);
    vecs[18] = mk(0, 32'h0,        0, 0, 5'd0,  6'b1,    0, 5'd14, 32'h0,         0, 1, 0, 32'h0000_2000, 32'h0000_2000);
    vecs[19] = mk(0, 32'h0,        0, 0, 5'd0,  6'b1,    0, 5'd13, 32'h0,         0, 1, 0, 32'h0000_2000, 32'h0000_0400);
    vecs[20] = mk(0, 32'h0,        0, 0, 5'd0,  6'b1,    1, 5'd12, 32'h0,         0, 1, 0, 32'h0000_2000, 32'h0000_0403);
    vecs[21] = mk(0, 32'h0,        0, 0, 5'd0,  6'b1,    0, 5'd12, 32'h0,         0, 1, 0, 32'h0000_2000, 32'h0);
    vecs[22] = mk(0, 32'h0,        0, 0, 5'd0,  6'b1,    1, 5'd12, 32'h0000_0801, 0, 1, 0, 32'h0000_2000, 32'h0);
    vecs[23] = mk(0, 32'h0,        0, 0, 5'd0,  6'b1,    0, 5'd12, 32'h0,         0, 1, 0, 32'h0000_2000, 32'h0000_0801);
    vecs[24] = mk(0, 32'h0000_2100,0, 0, 5'd0,  6'b11,   0, 5'd12, 32'h0,         0, 1, 1, 32'h0000_2000, 32'h0000_0801);
    vecs[25] = mk(0, 32'h0,        0, 0, 5'd0,  6'b11,   0, 5'd13, 32'h0,         0, 1, 0, 32'h0000_2100, 32'h0000_0C00);
    vecs[26] = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd14, 32'h0,         1, 1, 0, 32'h0000_2100, 32'h0000_2100);
    vecs[27] = mk(1, 32'h0000_5000,0, 1, 5'd10, 6'b0,    0, 5'd12, 32'h0,         0, 1, 1, 32'h0000_2100, 32'h0000_0801);
    vecs[28] = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd12, 32'h0,         0, 1, 0, 32'h0,         32'h0);
    vecs[29] = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd13, 32'h0,         0, 1, 0, 32'h0,         32'h0);
    vecs[30] = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd14, 32'h0,         0, 1, 0, 32'h0,         32'h0);
    vecs[31] = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    1, 5'd14, 32'h0000_3003, 1, 1, 0, FWD_EPC,       32'h0);
    vecs[32] = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    1, 5'd14, 32'h0000_3003, 0, 1, 0, FWD_EPC,       32'h0);
    vecs[33] = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd14, 32'h0,         0, 1, 0, 32'h0000_3000, 32'h0000_3000);
    vecs[34] = mk(0, 32'h0,        1, 1, 5'd4,  6'b0,    0, 5'd12, 32'h0,         0, 1, 1, 32'h0000_3000, 32'h0);
    vecs[35] = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd14, 32'h0,         0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    vecs[36] = mk(0, 32'h0,        0, 0, 5'd0,  6'b0,    0, 5'd13, 32'h0,         0, 1, 0, 32'hFFFF_FFFC, 32'h8000_0010);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      pc_m      = vecs[i].pc;
      bd_m      = vecs[i].bd;
      exc_valid = vecs[i].ev;
      exc_code  = vecs[i].code;
      hw_int    = vecs[i].hw;
      cp0_we    = vecs[i].we;
      cp0_addr  = vecs[i].addr;
      cp0_wdata = vecs[i].wdata;
      eret_m    = vecs[i].eret;
      #2;
      if (vecs[i].chk) begin
        check32("exc_taken", i, {31'b0, exc_taken}, {31'b0, vecs[i].x_taken});
        check32("epc_out",   i, epc_out,   vecs[i].x_epc);
        check32("cp0_rdata", i, cp0_rdata, vecs[i].x_rdata);
      end
    end

    // Cause.IP follows hw_int every edge even while EXL masks the lines.
    @(negedge clk);
    hw_int   = 6'b101010;
    cp0_addr = 5'd13;
    #2;
    check32("masked_taken", 100, {31'b0, exc_taken}, 32'h0);
    @(negedge clk);
    #2;
    check32("cause_ip", 101, cp0_rdata, 32'h8000_A810);

    // A second internal exception under EXL leaves EPC and Cause untouched.
    @(negedge clk);
    exc_valid = 1'b1;
    exc_code  = 5'd5;
    pc_m      = 32'h0000_7000;
    bd_m      = 1'b0;
    hw_int    = 6'b0;
    #2;
    check32("exl_block", 102, {31'b0, exc_taken}, 32'h0);
    @(negedge clk);
    exc_valid = 1'b0;
    cp0_addr  = 5'd14;
    #2;
    check32("epc_hold", 103, cp0_rdata, 32'hFFFF_FFFC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
